castd8_u2s_stream: RTL

//  Streaming unsigned-to-signed 8-bit cast for the SR-LUT datapath: the return path of the signed-to-unsigned cast.

---
 rtl/castd8_u2s_stream_if.sv | 21 ++
 rtl/castd8_u2s_stream.sv | 80 ++++++++
 2 files changed

// File: rtl/castd8_u2s_stream_if.sv
// castd8_u2s_stream_if: input pixel stream and output signed/idx/frac stream of the u2s cast
interface castd8_u2s_stream_if #(
  parameter int LANES = 4,
  parameter int FRAC_BITS = 4
);
  localparam int IW = 8 - FRAC_BITS;
  logic in_valid, in_ready, in_last;
  logic [8*LANES-1:0] in_x;
  logic out_valid, out_ready, out_last;
  logic [8*LANES-1:0] out_y;
  logic [IW*LANES-1:0] out_idx;
  logic [FRAC_BITS*LANES-1:0] out_frac;
  modport master (
    output in_valid, in_x, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_idx, out_frac, out_last
  );
  modport slave (
    input  in_valid, in_x, in_last, out_ready,
    output in_ready, out_valid, out_y, out_idx, out_frac, out_last
  );
endinterface

// File: rtl/castd8_u2s_stream.sv
// castd8_u2s_stream: 2-stage unsigned-to-signed pixel cast with LUT index/fraction split
module castd8_u2s_stream #(
  parameter int LANES = 4,
  parameter int FRAC_BITS = 4,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  castd8_u2s_stream_if.slave s,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic frame_done_o
);
  localparam int IW = 8 - FRAC_BITS;
  localparam int W = 8 * LANES;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [W-1:0] s1_y_q, s1_y_d;
  logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [W-1:0] s2_y_q, s2_y_d;
  logic [IW*LANES-1:0] s2_idx_q, s2_idx_d, idx_w;
  logic [FRAC_BITS*LANES-1:0] s2_frac_q, s2_frac_d, frac_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic s1_ready, s2_ready, in_fire, s1_move, out_fire;
  // the top IW bits of a two's-complement byte are exactly y >>> FRAC_BITS
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign idx_w[IW*k +: IW] = s1_y_q[8*k+FRAC_BITS +: IW];
    assign frac_w[FRAC_BITS*k +: FRAC_BITS] = s1_y_q[8*k +: FRAC_BITS];
  end
  assign s2_ready = !s2_valid_q || s.out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s.in_ready = s1_ready && !flush_i;
  assign in_fire = s.in_valid && s.in_ready;
  assign s1_move = s1_valid_q && s2_ready;
  assign out_fire = s2_valid_q && s.out_ready;
  always_comb begin
    s1_valid_d = flush_i ? 1'b0 : (s1_ready ? s.in_valid : s1_valid_q);
    s1_y_d = in_fire ? s.in_x ^ {LANES{8'h80}} : s1_y_q;
    s1_last_d = in_fire ? s.in_last : s1_last_q;
    s2_valid_d = flush_i ? 1'b0 : (s2_ready ? s1_valid_q : s2_valid_q);
    s2_y_d = s1_move ? s1_y_q : s2_y_q;
    s2_idx_d = s1_move ? idx_w : s2_idx_q;
    s2_frac_d = s1_move ? frac_w : s2_frac_q;
    s2_last_d = s1_move ? s1_last_q : s2_last_q;
    cnt_d = flush_i ? '0 : (out_fire ? (s2_last_q ? '0 : cnt_q + 1'b1) : cnt_q);
    done_d = !flush_i && out_fire && s2_last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_y_q <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_y_q <= '0;
      s2_idx_q <= '0;
      s2_frac_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_y_q <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q <= s2_last_d;
      s2_y_q <= s2_y_d;
      s2_idx_q <= s2_idx_d;
      s2_frac_q <= s2_frac_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  assign s.out_valid = s2_valid_q;
  assign s.out_y = s2_y_q;
  assign s.out_idx = s2_idx_q;
  assign s.out_frac = s2_frac_q;
  assign s.out_last = s2_last_q;
  assign beat_cnt_o = cnt_q;
  assign frame_done_o = done_q;
endmodule
